// File: rtl/layer1_rx_pkg.sv
// Shared types for the layer-1 receive source arbiter: FSM states and source index type.
package layer1_rx_pkg;

   localparam int unsigned NumSrc = 4;

   typedef logic [$clog2(NumSrc)-1:0] src_id_t;

   typedef enum logic [1:0] {
      StIdle,
      StPass,
      StDrain
   } state_e;

endpackage

// File: rtl/layer1_rx_src_arb_if.sv
// Bundled source-side and output-side AXI-Stream signals of the receive arbiter.
interface layer1_rx_src_arb_if #(
   parameter int unsigned N_SRC  = 4,
   parameter int unsigned DATA_W = 64
);

   logic [N_SRC-1:0]             s_axis_tvalid;
   logic [N_SRC-1:0]             s_axis_tready;
   logic [N_SRC-1:0][DATA_W-1:0] s_axis_tdata;
   logic [N_SRC-1:0]             s_axis_tlast;

   logic                         m_axis_output_tvalid;
   logic                         m_axis_output_tready;
   logic [DATA_W-1:0]            m_axis_output_tdata;
   logic                         m_axis_output_tlast;

   // Environment side: drives the sources and the output back-pressure.
   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_output_tready,
      input  s_axis_tready, m_axis_output_tvalid, m_axis_output_tdata, m_axis_output_tlast
   );

   // Arbiter side.
   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_output_tready,
      output s_axis_tready, m_axis_output_tvalid, m_axis_output_tdata, m_axis_output_tlast
   );

endinterface

// File: rtl/layer1_rr_pick.sv
// Combinational rotating-priority picker: first requester after ptr_i, wrapping modulo N_SRC.
module layer1_rr_pick
   import layer1_rx_pkg::*;
#(
   parameter int unsigned N_SRC = NumSrc
) (
   input  logic [N_SRC-1:0]         req_i,
   input  logic [$clog2(N_SRC)-1:0] ptr_i,
   output logic                     gnt_vld_o,
   output logic [$clog2(N_SRC)-1:0] gnt_id_o
);

   localparam int unsigned IdW = $clog2(N_SRC);

   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_id_o  = '0;
      for (int unsigned i = 1; i <= N_SRC; i++) begin
         logic [IdW-1:0] idx;
         idx = IdW'((32'(ptr_i) + i) % N_SRC);
         if (!gnt_vld_o && req_i[idx]) begin
            gnt_vld_o = 1'b1;
            gnt_id_o  = idx;
         end
      end
   end

endmodule

// File: rtl/layer1_rx_src_arb.sv
// Frame-atomic arbiter sharing one output stream between N_SRC sources, with frame-length
// truncation: beats past cfg_max_beats are drained from the source and never forwarded.
module layer1_rx_src_arb
   import layer1_rx_pkg::*;
#(
   parameter int unsigned N_SRC  = NumSrc,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned BEAT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   layer1_rx_src_arb_if.slave       axis,
   input  logic                     cfg_rr_en,
   input  logic [$clog2(N_SRC)-1:0] cfg_sel,
   input  logic [BEAT_W-1:0]        cfg_max_beats,
   output logic [$clog2(N_SRC)-1:0] grant_id,
   output logic                     busy,
   output logic [31:0]              frame_cnt,
   output logic [15:0]              overrun_cnt
);

   localparam int unsigned IdW = $clog2(N_SRC);

   state_e            state_q, state_d;
   logic [IdW-1:0]    grant_q, grant_d;
   logic [IdW-1:0]    ptr_q, ptr_d;
   logic [BEAT_W-1:0] max_q, max_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [31:0]       frame_q, frame_d;
   logic [15:0]       ovr_q, ovr_d;

   logic              pick_vld;
   logic [IdW-1:0]    pick_id;
   logic              sel_ok;
   logic              g_valid, g_last, hs, force_last;
   logic [DATA_W-1:0] g_data;

   layer1_rr_pick #(
      .N_SRC(N_SRC)
   ) u_pick (
      .req_i    (axis.s_axis_tvalid),
      .ptr_i    (ptr_q),
      .gnt_vld_o(pick_vld),
      .gnt_id_o (pick_id)
   );

   assign sel_ok  = 32'(cfg_sel) < N_SRC;
   assign g_valid = axis.s_axis_tvalid[grant_q];
   assign g_last  = axis.s_axis_tlast[grant_q];
   assign g_data  = axis.s_axis_tdata[grant_q];
   assign hs      = g_valid & axis.m_axis_output_tready;
   // The beat at index max-1 is the last one forwarded; a zero limit disables truncation.
   assign force_last = (max_q != '0) && (beat_q == max_q - BEAT_W'(1));

   assign axis.m_axis_output_tdata = g_data;
   assign grant_id    = grant_q;
   assign busy        = (state_q != StIdle);
   assign frame_cnt   = frame_q;
   assign overrun_cnt = ovr_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      max_d   = max_q;
      beat_d  = beat_q;
      frame_d = frame_q;
      ovr_d   = ovr_q;
      axis.s_axis_tready        = '0;
      axis.m_axis_output_tvalid = 1'b0;
      axis.m_axis_output_tlast  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cfg_rr_en ? pick_vld : (sel_ok && axis.s_axis_tvalid[cfg_sel])) begin
               grant_d = cfg_rr_en ? pick_id : cfg_sel;
               ptr_d   = grant_d;
               max_d   = cfg_max_beats;
               beat_d  = '0;
               state_d = StPass;
            end
         end
         StPass: begin
            axis.m_axis_output_tvalid    = g_valid;
            axis.m_axis_output_tlast     = g_last | force_last;
            axis.s_axis_tready[grant_q]  = axis.m_axis_output_tready;
            if (hs) begin
               beat_d = beat_q + BEAT_W'(1);
               if (g_last) begin
                  frame_d = frame_q + 32'd1;
                  state_d = StIdle;
               end else if (force_last) begin
                  ovr_d   = (ovr_q == 16'hFFFF) ? ovr_q : ovr_q + 16'd1;
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            axis.s_axis_tready[grant_q] = 1'b1;
            if (g_valid && g_last) begin
               frame_d = frame_q + 32'd1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         ptr_q   <= IdW'(N_SRC - 1);
         max_q   <= '0;
         beat_q  <= '0;
         frame_q <= '0;
         ovr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         max_q   <= max_d;
         beat_q  <= beat_d;
         frame_q <= frame_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_layer1_rx_src_arb.sv
// Directed and randomized bench for layer1_rx_src_arb against a frame-level reference model.
module tb_layer1_rx_src_arb;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_rr_en;
   logic [1:0]  cfg_sel;
   logic [15:0] cfg_max_beats;
   logic [1:0]  grant_id;
   logic        busy;
   logic [31:0] frame_cnt;
   logic [15:0] overrun_cnt;

   always #5 clk = ~clk;

   layer1_rx_src_arb_if #(.N_SRC(N), .DATA_W(64)) axis ();

   layer1_rx_src_arb #(
      .N_SRC (N),
      .DATA_W(64),
      .BEAT_W(16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .axis         (axis),
      .cfg_rr_en    (cfg_rr_en),
      .cfg_sel      (cfg_sel),
      .cfg_max_beats(cfg_max_beats),
      .grant_id     (grant_id),
      .busy         (busy),
      .frame_cnt    (frame_cnt),
      .overrun_cnt  (overrun_cnt)
   );

   int          checks = 0;
   int          errors = 0;
   string       cur = "init";
   int          rdy_pct = 100;
   logic [64:0] src_q [N][$];
   int          exp_grant [$];
   logic [64:0] exp_out [$];
   logic [64:0] obs_out [$];
   int          exp_ovr;

   logic        smp_busy, smp_mv, smp_mr, smp_last_hs;
   logic [1:0]  smp_gid;
   logic [3:0]  smp_tr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, exp);
      end
   endtask

   task automatic add_frame(input int src, input int len);
      for (int b = 0; b < len; b++) begin
         logic        l;
         logic [63:0] d;
         l = (b == len - 1);
         d = {$urandom, $urandom};
         src_q[src].push_back({l, d});
      end
   endtask

   // Frame-level model: which source gets each frame and what beats reach the output.
   task automatic build_plan(input bit rr, input int sel, input int maxb);
      logic [64:0] mq [N][$];
      int ptr;
      for (int i = 0; i < N; i++) mq[i] = src_q[i];
      exp_grant.delete();
      exp_out.delete();
      exp_ovr = 0;
      ptr = N - 1;
      while (1) begin
         int  pick;
         int  n;
         bit  done;
         pick = -1;
         if (rr) begin
            for (int i = 1; i <= N; i++)
               if (pick < 0 && mq[(ptr + i) % N].size() > 0) pick = (ptr + i) % N;
         end else if (mq[sel].size() > 0) begin
            pick = sel;
         end
         if (pick < 0) break;
         ptr = pick;
         exp_grant.push_back(pick);
         n = 0;
         done = 0;
         while (!done) begin
            logic [64:0] beat;
            beat = mq[pick].pop_front();
            done = beat[64];
            if (maxb == 0 || n < maxb) begin
               logic cut;
               cut = (maxb != 0 && n == maxb - 1);
               exp_out.push_back({beat[64] | cut, beat[63:0]});
               if (cut && !beat[64]) exp_ovr++;
            end
            n++;
         end
      end
   endtask

   task automatic tick();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            axis.s_axis_tvalid[i] = 1'b1;
            axis.s_axis_tdata[i]  = src_q[i][0][63:0];
            axis.s_axis_tlast[i]  = src_q[i][0][64];
         end else begin
            axis.s_axis_tvalid[i] = 1'b0;
            axis.s_axis_tdata[i]  = '0;
            axis.s_axis_tlast[i]  = 1'b0;
         end
      end
      axis.m_axis_output_tready = ($urandom_range(99) < rdy_pct);
      #3;
      smp_busy    = busy;
      smp_gid     = grant_id;
      smp_mv      = axis.m_axis_output_tvalid;
      smp_mr      = axis.m_axis_output_tready;
      smp_tr      = axis.s_axis_tready;
      smp_last_hs = 1'b0;
      if (smp_mv && smp_mr)
         obs_out.push_back({axis.m_axis_output_tlast, axis.m_axis_output_tdata});
      for (int i = 0; i < N; i++) begin
         if (axis.s_axis_tvalid[i] && axis.s_axis_tready[i]) begin
            if (src_q[i][0][64]) smp_last_hs = 1'b1;
            void'(src_q[i].pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) src_q[i].delete();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_overrun_cnt", overrun_cnt, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_m_tvalid", axis.m_axis_output_tvalid, 0);
      chk("rst_s_tready", axis.s_axis_tready, 0);
   endtask

   task automatic run_plan(input bit rr, input int sel, input int maxb, input int pct);
      int k;
      int idle;
      int cyc;
      cfg_rr_en     = rr;
      cfg_sel       = 2'(sel);
      cfg_max_beats = 16'(maxb);
      rdy_pct       = pct;
      build_plan(rr, sel, maxb);
      obs_out.delete();
      k = 0;
      idle = 0;
      cyc = 0;
      while (k < exp_grant.size() && cyc < 3000) begin
         tick();
         cyc++;
         if (!smp_busy) begin
            idle++;
            chk("idle_s_tready", smp_tr, 0);
            chk("idle_m_tvalid", smp_mv, 0);
         end else begin
            chk("grant", smp_gid, exp_grant[k]);
            if (smp_mv) chk("ready_mirror", smp_tr, smp_mr ? (1 << exp_grant[k]) : 0);
            else        chk("drain_s_tready", smp_tr, 1 << exp_grant[k]);
         end
         if (smp_last_hs) k++;
      end
      chk("frames_done", k, exp_grant.size());
      chk("idle_cycles", idle, exp_grant.size());
      chk("beat_count", obs_out.size(), exp_out.size());
      for (int j = 0; j < obs_out.size() && j < exp_out.size(); j++) begin
         chk("beat_data", obs_out[j][63:0], exp_out[j][63:0]);
         chk("beat_last", obs_out[j][64], exp_out[j][64]);
      end
      chk("frame_cnt", frame_cnt, exp_grant.size());
      chk("overrun_cnt", overrun_cnt, exp_ovr);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      int maxtab [5];
      maxtab = '{0, 1, 3, 5, 8};
      reset         = 1'b1;
      cfg_rr_en     = 1'b0;
      cfg_sel       = '0;
      cfg_max_beats = '0;
      axis.s_axis_tvalid        = '0;
      axis.s_axis_tdata         = '0;
      axis.s_axis_tlast         = '0;
      axis.m_axis_output_tready = 1'b0;
      @(posedge clk);
      #1;

      cur = "fixed_sel2";
      do_reset();
      add_frame(2, 5);
      add_frame(0, 3);
      add_frame(1, 2);
      add_frame(3, 4);
      run_plan(0, 2, 0, 100);

      cur = "rr_all";
      do_reset();
      add_frame(0, 3);
      add_frame(0, 3);
      add_frame(1, 3);
      add_frame(2, 3);
      add_frame(3, 3);
      run_plan(1, 0, 0, 100);

      cur = "overrun";
      do_reset();
      add_frame(1, 10);
      run_plan(0, 1, 4, 100);

      cur = "exact_max";
      do_reset();
      add_frame(0, 4);
      run_plan(0, 0, 4, 100);

      cur = "backpressure";
      do_reset();
      add_frame(2, 16);
      run_plan(1, 0, 0, 50);

      for (int r = 0; r < 6; r++) begin
         cur = $sformatf("random%0d", r);
         do_reset();
         for (int s = 0; s < N; s++)
            for (int f = $urandom_range(3); f > 0; f--) add_frame(s, $urandom_range(12, 1));
         run_plan(r != 5, $urandom_range(N - 1), maxtab[$urandom_range(4)],
                  $urandom_range(100, 30));
      end

      cur = "mid_reset";
      do_reset();
      add_frame(0, 5);
      run_plan(1, 0, 3, 100);
      add_frame(1, 8);
      add_frame(3, 4);
      rdy_pct = 100;
      cfg_max_beats = '0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_frame_cnt", frame_cnt, 0);
      chk("mid_rst_overrun_cnt", overrun_cnt, 0);
      chk("mid_rst_grant_id", grant_id, 0);
      tick();
      chk("post_rst_idle", smp_busy, 0);
      chk("post_rst_busy", busy, 1);
      chk("post_rst_grant", grant_id, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
